// File: rtl/l4_port_parser.sv
// L4 port parser: extracts UDP/TCP ports (plus UDP length) behind the IPv4 header parser and
// forwards the beat stream with one cycle of latency. Define L4_TCP_FLAGS_EN to capture TCP flags.
module l4_port_parser #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           tdata_in,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] idx_in,
    input  logic                            data_valid_in,
    input  logic                            last_flag_in,
    input  logic                            ipv4_ready_in,
    input  logic [4:0]                      start_lane_in,
    input  logic [7:0]                      protocol_in,
    output logic [DATA_WIDTH-1:0]           tdata_out,
    output logic [$clog2(DATA_WIDTH/8)-1:0] idx_out,
    output logic                            data_valid_out,
    output logic                            last_flag_out,
    output logic [4:0]                      payload_lane_out,
    output logic                            l4_parser_ready,
    output logic                            l4_unsupported,
    output logic                            hdr_error,
    output logic [15:0]                     src_port,
    output logic [15:0]                     dst_port,
    output logic [15:0]                     udp_length,
    output logic [7:0]                      tcp_flags
);

    localparam int Lanes = int'(DATA_WIDTH / 8);
    localparam int IdxW = $clog2(DATA_WIDTH / 8);
    localparam logic [7:0] ProtoTcp = 8'd6;
    localparam logic [7:0] ProtoUdp = 8'd17;
    localparam logic [4:0] UdpHlen = 5'd8;
`ifdef L4_TCP_FLAGS_EN
    localparam logic [4:0] TcpHlen = 5'd14;
`else
    localparam logic [4:0] TcpHlen = 5'd4;
`endif

    typedef enum logic [1:0] {StIdle, StHdr, StPayload, StSkip} state_e;

    state_e state_q, state_d;
    logic [7:0]  proto_q, proto_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] cap_src_q, cap_src_d, cap_dst_q, cap_dst_d, cap_len_q, cap_len_d;
    logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
    logic [7:0]  flg_q, flg_d;
    logic        ready_q, ready_d, unsup_q, unsup_d, err_q, err_d;
    logic [4:0]  plane_q, plane_d;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic [IdxW-1:0]       idx_q;
    logic                  valid_q, last_q;

    logic        parse, done, is_udp;
    logic [7:0]  cur_proto;
    logic [4:0]  lo, cnt_v, lane_v, plane_v, hlen;
`ifdef L4_TCP_FLAGS_EN
    logic [7:0]  cap_flg_q, cap_flg_d;
`endif

    always_comb begin
        state_d   = state_q;
        proto_d   = proto_q;
        cnt_d     = cnt_q;
        cap_src_d = cap_src_q;
        cap_dst_d = cap_dst_q;
        cap_len_d = cap_len_q;
`ifdef L4_TCP_FLAGS_EN
        cap_flg_d = cap_flg_q;
`endif
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        flg_d     = flg_q;
        ready_d   = ready_q;
        unsup_d   = unsup_q;
        err_d     = 1'b0;
        plane_d   = 5'd0;
        parse     = 1'b0;
        done      = 1'b0;
        cur_proto = proto_q;
        lo        = 5'd0;
        cnt_v     = cnt_q;
        lane_v    = 5'd0;
        plane_v   = 5'd0;

        unique case (state_q)
            StIdle: begin
                // A header that finished on the last beat keeps ready for exactly one cycle.
                ready_d = 1'b0;
                unsup_d = 1'b0;
                cnt_d   = 5'd0;
                if (data_valid_in && ipv4_ready_in) begin
                    proto_d   = protocol_in;
                    cur_proto = protocol_in;
                    if (protocol_in == ProtoUdp || protocol_in == ProtoTcp) begin
                        parse     = 1'b1;
                        lo        = start_lane_in;
                        cnt_v     = 5'd0;
                        cap_src_d = '0;
                        cap_dst_d = '0;
                        cap_len_d = '0;
`ifdef L4_TCP_FLAGS_EN
                        cap_flg_d = '0;
`endif
                    end else begin
                        state_d = last_flag_in ? StIdle : StSkip;
                        ready_d = 1'b1;
                        unsup_d = 1'b1;
                        src_d   = '0;
                        dst_d   = '0;
                        len_d   = '0;
                        flg_d   = '0;
                    end
                end
            end
            StHdr: parse = data_valid_in && ipv4_ready_in;
            StPayload, StSkip: begin
                if (data_valid_in && last_flag_in) state_d = StIdle;
            end
        endcase

        hlen = (cur_proto == ProtoUdp) ? UdpHlen : TcpHlen;
        if (parse) begin
            for (int i = 0; i < Lanes; i++) begin
                lane_v = 5'(i);
                if (!done && lane_v >= lo && lane_v <= 5'(idx_in)) begin
                    case (cnt_v)
                        5'd0: cap_src_d[15:8] = tdata_in[i*8 +: 8];
                        5'd1: cap_src_d[7:0]  = tdata_in[i*8 +: 8];
                        5'd2: cap_dst_d[15:8] = tdata_in[i*8 +: 8];
                        5'd3: cap_dst_d[7:0]  = tdata_in[i*8 +: 8];
                        5'd4: cap_len_d[15:8] = tdata_in[i*8 +: 8];
                        5'd5: cap_len_d[7:0]  = tdata_in[i*8 +: 8];
`ifdef L4_TCP_FLAGS_EN
                        5'd13: cap_flg_d      = tdata_in[i*8 +: 8];
`endif
                        default: ;
                    endcase
                    cnt_v = cnt_v + 5'd1;
                    if (cnt_v == hlen) begin
                        done    = 1'b1;
                        plane_v = (lane_v == 5'(idx_in)) ? 5'd0 : lane_v + 5'd1;
                    end
                end
            end
            is_udp = (cur_proto == ProtoUdp);
            if (done) begin
                state_d = last_flag_in ? StIdle : StPayload;
                cnt_d   = 5'd0;
                ready_d = 1'b1;
                plane_d = plane_v;
                src_d   = cap_src_d;
                dst_d   = cap_dst_d;
                len_d   = is_udp ? cap_len_d : 16'd0;
`ifdef L4_TCP_FLAGS_EN
                flg_d   = is_udp ? 8'd0 : cap_flg_d;
`else
                flg_d   = 8'd0;
`endif
            end else if (last_flag_in) begin
                state_d = StIdle;
                cnt_d   = 5'd0;
                err_d   = 1'b1;
            end else begin
                state_d = StHdr;
                cnt_d   = cnt_v;
            end
        end else begin
            is_udp = 1'b0;
        end

        // Upstream dropping its header-valid level aborts the frame; fields keep their values.
        if (state_q != StIdle && !ipv4_ready_in) begin
            state_d = StIdle;
            cnt_d   = 5'd0;
            ready_d = 1'b0;
            unsup_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            proto_q   <= '0;
            cnt_q     <= '0;
            cap_src_q <= '0;
            cap_dst_q <= '0;
            cap_len_q <= '0;
`ifdef L4_TCP_FLAGS_EN
            cap_flg_q <= '0;
`endif
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            flg_q     <= '0;
            ready_q   <= 1'b0;
            unsup_q   <= 1'b0;
            err_q     <= 1'b0;
            plane_q   <= '0;
            tdata_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            proto_q   <= proto_d;
            cnt_q     <= cnt_d;
            cap_src_q <= cap_src_d;
            cap_dst_q <= cap_dst_d;
            cap_len_q <= cap_len_d;
`ifdef L4_TCP_FLAGS_EN
            cap_flg_q <= cap_flg_d;
`endif
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            flg_q     <= flg_d;
            ready_q   <= ready_d;
            unsup_q   <= unsup_d;
            err_q     <= err_d;
            plane_q   <= plane_d;
            tdata_q   <= tdata_in;
            idx_q     <= idx_in;
            valid_q   <= data_valid_in;
            last_q    <= last_flag_in;
        end
    end

    assign tdata_out        = tdata_q;
    assign idx_out          = idx_q;
    assign data_valid_out   = valid_q;
    assign last_flag_out    = last_q;
    assign payload_lane_out = plane_q;
    assign l4_parser_ready  = ready_q;
    assign l4_unsupported   = unsup_q;
    assign hdr_error        = err_q;
    assign src_port         = src_q;
    assign dst_port         = dst_q;
    assign udp_length       = len_q;
    assign tcp_flags        = flg_q;

endmodule

// File: doc/l4_port_parser.md
Name: l4_port_parser

Overview:
- Stage directly downstream of the IPv4 header parser; consumes its registered beat stream, header-done level, start-lane and protocol outputs.
- Extracts the UDP or TCP port fields (plus UDP length, optionally TCP flags) starting at the byte lane where the IPv4 header ended.
- Forwards the beat stream with one cycle of latency toward the flow lookup stage.

Parameters:
DATA_WIDTH, 64, beat width in bits; must be a multiple of 8; byte lane i = tdata[i*8 +: 8]; lane 0 is first on the wire.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
tdata_in  in  DATA_WIDTH  beat data
idx_in  in  $clog2(DATA_WIDTH/8)  index of last valid lane in the beat
data_valid_in  in  1  beat valid
last_flag_in  in  1  last beat of frame
ipv4_ready_in  in  1  IPv4 header complete; level, held until end of frame
start_lane_in  in  5  first L4 lane in the beat where ipv4_ready_in rises; 0 otherwise
protocol_in  in  8  IPv4 protocol field, stable while ipv4_ready_in=1
tdata_out  out  DATA_WIDTH  registered tdata_in
idx_out  out  $clog2(DATA_WIDTH/8)  registered idx_in
data_valid_out  out  1  registered data_valid_in
last_flag_out  out  1  registered last_flag_in
payload_lane_out  out  5  first payload lane in the beat flagged by l4_ready rising; 0 otherwise
l4_parser_ready  out  1  L4 header complete (level)
l4_unsupported  out  1  protocol is neither 6 nor 17 (level, same lifetime as l4_parser_ready)
hdr_error  out  1  one-cycle pulse: frame ended before the L4 header completed
src_port  out  16  source port
dst_port  out  16  destination port
udp_length  out  16  UDP length field; 0 for TCP
tcp_flags  out  8  TCP flags byte; 0 for UDP

Behaviour:
- Reset: all outputs 0; FSM = IDLE; byte counter = 0. Reset wins over any concurrent beat.
- Pass-through: tdata/idx/valid/last are registered every cycle, unconditionally, with 1-cycle latency.
- Field outputs are registered. They are aligned with the pass-through beat in which the header completes.
- Byte counter: 5 bits; counts L4 header bytes already consumed. Processing within a beat runs from lane (first beat ? start_lane_in : 0) to idx_in. Multiple header bytes per beat are handled.
- Byte order: network order; header byte n lands in field MSB-first. Examples: src_port = {byte0, byte1}; udp_length = {byte4, byte5}; tcp_flags = byte13.
- Header length (HLEN): UDP = 8; TCP = 4 (14 with L4_TCP_FLAGS_EN).

FSM:
- IDLE
  - On data_valid_in && ipv4_ready_in: latch protocol_in.
  - Protocol 17 or 6 -> go to HDR and start parsing at start_lane_in in the same beat.
  - Any other protocol -> go to SKIP; set l4_parser_ready=1 and l4_unsupported=1; ports stay 0.
- HDR
  - Consume bytes each valid beat.
  - When counter reaches HLEN: set l4_parser_ready=1; payload_lane_out = lane after the last header byte; go to PAYLOAD.
  - If HLEN ends exactly on lane idx_in, payload_lane_out = 0 and the payload starts on the next beat.
  - If last_flag_in arrives before HLEN: pulse hdr_error; l4_parser_ready stays 0; go to IDLE.
- PAYLOAD / SKIP
  - Hold fields.
  - On the beat after the last_flag_in beat, clear l4_parser_ready and l4_unsupported and go to IDLE.
- Global abort: ipv4_ready_in low while not in IDLE -> clear ready flags and go to IDLE; port/field registers keep their last values.
- Header completing in the last beat: ready asserts, then clears on the following cycle per the PAYLOAD rule.
- Bubbles: data_valid_in=0 cycles do not advance the counter or the FSM.

Optional Feature:
- Macro: L4_TCP_FLAGS_EN.
- Defined: TCP HLEN = 14; tcp_flags captures header byte 13. A TCP frame ending with fewer than 14 L4 bytes raises hdr_error.
- Undefined: TCP HLEN = 4; tcp_flags is tied to 0; no flag-capture logic is synthesized.

Test Plan:
- UDP, start_lane_in=2: ports 0x1234->0x0050, length 0x001C. Expect src_port=0x1234, dst_port=0x0050, udp_length=0x001C. l4_parser_ready rises on the pass-through of the second beat with payload_lane_out=2.
- TCP with L4_TCP_FLAGS_EN, start_lane_in=6, flags 0x12: expect ports correct, tcp_flags=0x12, ready on the third beat, payload_lane_out=4. Without the macro, ready rises on the second beat, tcp_flags=0.
- Protocol 1 (ICMP): l4_unsupported=1 and l4_parser_ready=1 in the first beat, ports 0. Both clear after the last beat.
- UDP frame with last_flag_in at L4 byte 5: one-cycle hdr_error, l4_parser_ready never set; the next frame parses normally.
- Valid bubbles every other cycle plus rst asserted mid-HDR: counter holds across bubbles; after rst, all outputs = 0 and the FSM is in IDLE.
- ipv4_ready_in drops mid-PAYLOAD: l4_parser_ready clears the next cycle; the pass-through stream is unaffected.
